csr_intr_unit: RTL

Control/status register file with stable-counter timer and interrupt detection for the five-stage pipeline. It holds the exception CSRs, records exception commit and `ertn` at WB, and generates the exception and return target PCs. It also samples hardware, inter-processor and timer interrupt sources and flags a pending enabled interrupt to ID. It is parametrised in timer width, hardware-interrupt line count and core ID.

---
 rtl/csr_intr_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/csr_intr_unit.sv
// Exception/interrupt CSR file: exception and ertn commit, stable-counter timer,
// interrupt sampling and pending-interrupt detection for the five-stage pipeline.
module csr_intr_unit #(
    parameter int          TIMER_W  = 32,
    parameter int          HWI_N    = 8,
    parameter logic [31:0] TID_INIT = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             csr_re,
    input  logic [13:0]      csr_rd_num,
    output logic [31:0]      csr_rd_value,
    input  logic             csr_we,
    input  logic [13:0]      csr_wr_num,
    input  logic [31:0]      csr_wr_mask,
    input  logic [31:0]      csr_wr_value,
    input  logic             wb_exc,
    input  logic [5:0]       wb_ecode,
    input  logic [8:0]       wb_esubcode,
    input  logic [31:0]      wb_pc,
    input  logic [31:0]      wb_vaddr,
    input  logic             ertn_flush,
    input  logic [HWI_N-1:0] hw_int_in,
    input  logic             ipi_int_in,
    output logic             has_int,
    output logic [31:0]      ex_entry,
    output logic [31:0]      ertn_pc
);
    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;
    localparam logic [TIMER_W-1:0] TV_ONE = TIMER_W'(1);

    logic [3:0]         crmd_reg;
    logic [2:0]         prmd_reg;
    logic [12:0]        ecfg_reg;
    logic [1:0]         is_sw_reg;
    logic [HWI_N-1:0]   is_hw_reg;
    logic               is_timer_reg;
    logic               is_ipi_reg;
    logic [5:0]         ecode_reg;
    logic [8:0]         esubcode_reg;
    logic [31:0]        era_reg;
    logic [31:0]        badv_reg;
    logic [25:0]        eentry_reg;
    logic [31:0]        save_reg [4];
    logic [31:0]        tid_reg;
    logic [TIMER_W-1:0] tcfg_reg;
    logic [TIMER_W-1:0] tval_reg;

    logic               wr_en;
    logic               tcfg_we;
    logic               ticlr_clr;
    logic               timer_expire;
    logic [TIMER_W-1:0] tcfg_next;
    logic [TIMER_W-1:0] tval_next;
    logic [12:0]        is_vec;
    logic               unused_inputs;

    // Commits own the cycle: a concurrent WB write is dropped entirely.
    assign wr_en     = csr_we & ~wb_exc & ~ertn_flush;
    assign tcfg_we   = wr_en && (csr_wr_num == CSR_TCFG);
    assign ticlr_clr = wr_en && (csr_wr_num == CSR_TICLR) && csr_wr_mask[0] && csr_wr_value[0];
    assign tcfg_next = (tcfg_reg & ~csr_wr_mask[TIMER_W-1:0])
                     | (csr_wr_value[TIMER_W-1:0] & csr_wr_mask[TIMER_W-1:0]);
    assign timer_expire  = tcfg_reg[0] && (tval_reg == '0);
    assign unused_inputs = csr_re;

    assign is_vec[1:0]       = is_sw_reg;
    assign is_vec[2 +: HWI_N] = is_hw_reg;
    assign is_vec[10]        = 1'b0;
    assign is_vec[11]        = is_timer_reg;
    assign is_vec[12]        = is_ipi_reg;
    generate
        for (genvar gi = HWI_N; gi < 8; gi++) begin : g_is_pad
            assign is_vec[2 + gi] = 1'b0;
        end
    endgenerate

    assign has_int  = crmd_reg[2] & |(is_vec & ecfg_reg);
    assign ex_entry = {eentry_reg, 6'b0};
    assign ertn_pc  = era_reg;

    // A TCFG write enabling the timer restarts it; all-ones is the stopped state.
    always_comb begin
        tval_next = tval_reg;
        if (tcfg_we && tcfg_next[0]) begin
            tval_next = {tcfg_next[TIMER_W-1:2], 2'b00};
        end else if (tcfg_reg[0] && (tval_reg != '1)) begin
            if (timer_expire && tcfg_reg[1]) begin
                tval_next = {tcfg_reg[TIMER_W-1:2], 2'b00};
            end else begin
                tval_next = tval_reg - TV_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crmd_reg     <= 4'h8;
            prmd_reg     <= '0;
            ecfg_reg     <= '0;
            is_sw_reg    <= '0;
            is_hw_reg    <= '0;
            is_timer_reg <= 1'b0;
            is_ipi_reg   <= 1'b0;
            ecode_reg    <= '0;
            esubcode_reg <= '0;
            era_reg      <= '0;
            badv_reg     <= '0;
            eentry_reg   <= '0;
            for (int i = 0; i < 4; i++) save_reg[i] <= '0;
            tid_reg      <= TID_INIT;
            tcfg_reg     <= '0;
            tval_reg     <= '1;
        end else begin
            is_hw_reg  <= hw_int_in;
            is_ipi_reg <= ipi_int_in;
            tval_reg   <= tval_next;
            if (timer_expire) begin
                is_timer_reg <= 1'b1;
            end else if (ticlr_clr) begin
                is_timer_reg <= 1'b0;
            end
            if (wb_exc) begin
                prmd_reg      <= crmd_reg[2:0];
                crmd_reg[2:0] <= 3'b000;
                era_reg       <= wb_pc;
                ecode_reg     <= wb_ecode;
                esubcode_reg  <= wb_esubcode;
                if ((wb_ecode == 6'h08) || (wb_ecode == 6'h09)) badv_reg <= wb_vaddr;
            end else if (ertn_flush) begin
                crmd_reg[2:0] <= prmd_reg;
            end else if (csr_we) begin
                case (csr_wr_num)
                    CSR_CRMD:   crmd_reg <= (crmd_reg & ~csr_wr_mask[3:0]) | (csr_wr_value[3:0] & csr_wr_mask[3:0]);
                    CSR_PRMD:   prmd_reg <= (prmd_reg & ~csr_wr_mask[2:0]) | (csr_wr_value[2:0] & csr_wr_mask[2:0]);
                    CSR_ECFG:   ecfg_reg <= ((ecfg_reg & ~csr_wr_mask[12:0]) | (csr_wr_value[12:0] & csr_wr_mask[12:0]))
                                            & 13'h1BFF;
                    CSR_ESTAT:  is_sw_reg <= (is_sw_reg & ~csr_wr_mask[1:0]) | (csr_wr_value[1:0] & csr_wr_mask[1:0]);
                    CSR_ERA:    era_reg  <= (era_reg & ~csr_wr_mask) | (csr_wr_value & csr_wr_mask);
                    CSR_BADV:   badv_reg <= (badv_reg & ~csr_wr_mask) | (csr_wr_value & csr_wr_mask);
                    CSR_EENTRY: eentry_reg <= (eentry_reg & ~csr_wr_mask[31:6]) | (csr_wr_value[31:6] & csr_wr_mask[31:6]);
                    CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                        save_reg[csr_wr_num[1:0]] <= (save_reg[csr_wr_num[1:0]] & ~csr_wr_mask)
                                                   | (csr_wr_value & csr_wr_mask);
                    CSR_TID:    tid_reg  <= (tid_reg & ~csr_wr_mask) | (csr_wr_value & csr_wr_mask);
                    CSR_TCFG:   tcfg_reg <= tcfg_next;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        csr_rd_value = '0;
        case (csr_rd_num)
            CSR_CRMD:   csr_rd_value[3:0]  = crmd_reg;
            CSR_PRMD:   csr_rd_value[2:0]  = prmd_reg;
            CSR_ECFG:   csr_rd_value[12:0] = ecfg_reg;
            CSR_ESTAT: begin
                csr_rd_value[12:0]  = is_vec;
                csr_rd_value[21:16] = ecode_reg;
                csr_rd_value[30:22] = esubcode_reg;
            end
            CSR_ERA:    csr_rd_value = era_reg;
            CSR_BADV:   csr_rd_value = badv_reg;
            CSR_EENTRY: csr_rd_value = {eentry_reg, 6'b0};
            CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                        csr_rd_value = save_reg[csr_rd_num[1:0]];
            CSR_TID:    csr_rd_value = tid_reg;
            CSR_TCFG:   csr_rd_value[TIMER_W-1:0] = tcfg_reg;
            CSR_TVAL:   csr_rd_value[TIMER_W-1:0] = tval_reg;
            default: ;
        endcase
    end
endmodule
